// File: rtl/commutation_pkg.sv
// Shared definitions for the matrix-converter commutation path: gate-bit
// positions, phase codes, the legal gate patterns, fault codes and monitor
// states. Used by both the commutation FSM and its monitor.
package commutation_pkg;

    localparam int GATE_W = 6;

    // Gate bus bit positions
    localparam int A_FWD = 5;
    localparam int A_REV = 4;
    localparam int B_FWD = 3;
    localparam int B_REV = 2;
    localparam int C_FWD = 1;
    localparam int C_REV = 0;

    typedef enum logic [1:0] {
        PH_NUL = 2'b00,
        PH_A   = 2'b01,
        PH_B   = 2'b10,
        PH_C   = 2'b11
    } phase_t;

    // Full bidirectional pairs
    localparam logic [5:0] PAIR_A = 6'b110000;
    localparam logic [5:0] PAIR_B = 6'b001100;
    localparam logic [5:0] PAIR_C = 6'b000011;

    // Same-polarity overlaps of two phases
    localparam logic [5:0] OVL_AB_FWD = 6'b101000;
    localparam logic [5:0] OVL_AC_FWD = 6'b100010;
    localparam logic [5:0] OVL_BC_FWD = 6'b001010;
    localparam logic [5:0] OVL_AB_REV = 6'b010100;
    localparam logic [5:0] OVL_AC_REV = 6'b010001;
    localparam logic [5:0] OVL_BC_REV = 6'b000101;

    localparam int N_OVERLAP = 6;
    localparam logic [N_OVERLAP-1:0][5:0] OVERLAP_SET = {
        OVL_BC_REV, OVL_AC_REV, OVL_AB_REV,
        OVL_BC_FWD, OVL_AC_FWD, OVL_AB_FWD
    };

    typedef enum logic [2:0] {
        FLT_NONE    = 3'd0,
        FLT_ILLEGAL = 3'd1,
        FLT_JUMP    = 3'd2,
        FLT_DWELL   = 3'd3,
        FLT_OPEN    = 3'd4
    } fault_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CONDUCT   = 2'd1,
        ST_COMMUTATE = 2'd2,
        ST_FAULT     = 2'd3
    } mon_state_t;

    // Number of set bits in a gate pattern
    function automatic logic [2:0] popcount6(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/commutation_monitor_classify.sv
// Combinational decode of one gate pattern into its class (all-off, single
// switch, full pair, legal overlap, illegal) and the phase of a full pair.
module gate_pattern_classify
    import commutation_pkg::*;
(
    input  logic [5:0] pattern,
    output logic       is_zero,
    output logic       is_single,
    output logic       is_pair,
    output logic       is_overlap,
    output logic       is_illegal,
    output logic [1:0] pair_phase
);

    logic [N_OVERLAP-1:0] ovl_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_OVERLAP; gi++) begin : g_ovl
            assign ovl_hit[gi] = (pattern == OVERLAP_SET[gi]);
        end
    endgenerate

    // Classify the pattern; anything not recognised as legal is illegal
    always_comb begin
        pair_phase = PH_NUL;
        case (pattern)
            PAIR_A:  pair_phase = PH_A;
            PAIR_B:  pair_phase = PH_B;
            PAIR_C:  pair_phase = PH_C;
            default: pair_phase = PH_NUL;
        endcase
        is_zero    = (pattern == 6'b000000);
        is_single  = (popcount6(pattern) == 3'd1);
        is_pair    = (pair_phase != PH_NUL);
        is_overlap = |ovl_hit;
        is_illegal = !(is_zero || is_single || is_pair || is_overlap);
    end

endmodule

// File: rtl/commutation_monitor.sv
// Passive checker for the commutation FSM gate bus. Registers the bus twice,
// checks each pattern change against the four-step rules, latches the first
// violation as a coded fault and counts completed phase changes.
module commutation_monitor
    import commutation_pkg::*;
#(
    parameter int MIN_DWELL = 4,
    parameter int OPEN_MAX  = 2,
    parameter int DWELL_W   = 8,
    parameter int COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         gate_in,
    output logic [1:0]         active_phase,
    output logic               conducting,
    output logic               in_transition,
    output logic               fault,
    output logic [2:0]         fault_code,
    output logic [COUNT_W-1:0] comm_count
);

    localparam logic [DWELL_W-1:0] MIN_DWELL_C = DWELL_W'(MIN_DWELL);
    localparam logic [DWELL_W-1:0] OPEN_MAX_C  = DWELL_W'(OPEN_MAX);
    localparam logic [DWELL_W-1:0] CNT_SAT     = {DWELL_W{1'b1}};
    localparam logic [DWELL_W-1:0] DWELL_ONE   = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] COUNT_ONE   = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [5:0]         g_cur_reg, g_prev_reg;
    logic [DWELL_W-1:0] dwell_cnt_reg, open_cnt_reg;
    mon_state_t         state_reg, state_next;
    logic [1:0]         active_phase_reg, active_phase_next;
    logic               conducting_reg, conducting_next;
    logic               in_transition_reg, in_transition_next;
    logic               fault_reg, fault_next;
    logic [2:0]         fault_code_reg, fault_code_next;
    logic [COUNT_W-1:0] comm_count_reg, comm_count_next;

    logic       cls_zero, cls_single, cls_pair, cls_overlap, cls_illegal;
    logic [1:0] cls_phase;
    logic       changed, checked;
    logic [2:0] hamming;
    fault_t     viol_code;

    gate_pattern_classify u_classify (
        .pattern    (g_cur_reg),
        .is_zero    (cls_zero),
        .is_single  (cls_single),
        .is_pair    (cls_pair),
        .is_overlap (cls_overlap),
        .is_illegal (cls_illegal),
        .pair_phase (cls_phase)
    );

    assign changed = (g_cur_reg != g_prev_reg);
    // The first energisation out of all-off after reset is not a commutation,
    // so change rules and the open-circuit limit only apply once out of IDLE.
    assign checked = (state_reg != ST_IDLE);
    assign hamming = popcount6(g_cur_reg ^ g_prev_reg);

    // Input pipeline plus dwell and open-circuit counters
    always_ff @(posedge clk) begin
        if (rst) begin
            g_cur_reg     <= 6'b000000;
            g_prev_reg    <= 6'b000000;
            dwell_cnt_reg <= CNT_SAT;
            open_cnt_reg  <= '0;
        end else begin
            g_cur_reg  <= gate_in;
            g_prev_reg <= g_cur_reg;
            if (changed) begin
                dwell_cnt_reg <= DWELL_ONE;
            end else if (dwell_cnt_reg != CNT_SAT) begin
                dwell_cnt_reg <= dwell_cnt_reg + DWELL_ONE;
            end
            if (!cls_zero) begin
                open_cnt_reg <= '0;
            end else if (checked && open_cnt_reg != CNT_SAT) begin
                open_cnt_reg <= open_cnt_reg + DWELL_ONE;
            end
        end
    end

    // Violation detection; lowest code wins when several fire together
    always_comb begin
        viol_code = FLT_NONE;
        if (cls_illegal) begin
            viol_code = FLT_ILLEGAL;
        end else if (checked && changed && hamming != 3'd1) begin
            viol_code = FLT_JUMP;
        end else if (checked && changed && dwell_cnt_reg < MIN_DWELL_C) begin
            viol_code = FLT_DWELL;
        end else if (checked && cls_zero && open_cnt_reg >= OPEN_MAX_C) begin
            viol_code = FLT_OPEN;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_next         = state_reg;
        active_phase_next  = active_phase_reg;
        conducting_next    = 1'b0;
        in_transition_next = 1'b0;
        fault_next         = fault_reg;
        fault_code_next    = fault_code_reg;
        comm_count_next    = comm_count_reg;
        if (state_reg != ST_FAULT) begin
            if (viol_code != FLT_NONE) begin
                state_next      = ST_FAULT;
                fault_next      = 1'b1;
                fault_code_next = viol_code;
            end else begin
                conducting_next    = cls_pair;
                in_transition_next = cls_single || cls_overlap;
                if (cls_pair) begin
                    state_next        = ST_CONDUCT;
                    active_phase_next = cls_phase;
                    // A commutation completes only when a different phase
                    // takes over from one that was already established.
                    if (state_reg == ST_COMMUTATE && cls_phase != active_phase_reg &&
                        active_phase_reg != PH_NUL) begin
                        comm_count_next = comm_count_reg + COUNT_ONE;
                    end
                end else if (cls_zero && state_reg == ST_IDLE) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_COMMUTATE;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            active_phase_reg  <= PH_NUL;
            conducting_reg    <= 1'b0;
            in_transition_reg <= 1'b0;
            fault_reg         <= 1'b0;
            fault_code_reg    <= FLT_NONE;
            comm_count_reg    <= '0;
        end else begin
            state_reg         <= state_next;
            active_phase_reg  <= active_phase_next;
            conducting_reg    <= conducting_next;
            in_transition_reg <= in_transition_next;
            fault_reg         <= fault_next;
            fault_code_reg    <= fault_code_next;
            comm_count_reg    <= comm_count_next;
        end
    end

    assign active_phase  = active_phase_reg;
    assign conducting    = conducting_reg;
    assign in_transition = in_transition_reg;
    assign fault         = fault_reg;
    assign fault_code    = fault_code_reg;
    assign comm_count    = comm_count_reg;

endmodule

// File: tb/tb_commutation_monitor.sv
// Self-checking bench for commutation_monitor: a table of gate-pattern holds
// with expected steady outputs, plus hand-written edge-exact sequences for
// reset release and the open-circuit limit. Expectations go into a
// scoreboard queue when stimulus is driven and are compared when due.
module tb_commutation_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  gate_in = 6'b000000;

    logic [1:0]  active_phase, active_phase_w2;
    logic        conducting, conducting_w2;
    logic        in_transition, in_transition_w2;
    logic        fault, fault_w2;
    logic [2:0]  fault_code, fault_code_w2;
    logic [15:0] comm_count;
    logic [1:0]  comm_count_w2;

    typedef struct {
        logic [1:0]  ph;
        logic        cond;
        logic        trans;
        logic        flt;
        logic [2:0]  code;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        int   due;
        exp_t e;
    } sb_t;

    typedef struct {
        logic       rst;
        logic [5:0] gate;
        int         len;
        logic       chk;
        exp_t       e;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    commutation_monitor dut (
        .clk           (clk),
        .rst           (rst),
        .gate_in       (gate_in),
        .active_phase  (active_phase),
        .conducting    (conducting),
        .in_transition (in_transition),
        .fault         (fault),
        .fault_code    (fault_code),
        .comm_count    (comm_count)
    );

    commutation_monitor #(.COUNT_W(2)) dut_w2 (
        .clk           (clk),
        .rst           (rst),
        .gate_in       (gate_in),
        .active_phase  (active_phase_w2),
        .conducting    (conducting_w2),
        .in_transition (in_transition_w2),
        .fault         (fault_w2),
        .fault_code    (fault_code_w2),
        .comm_count    (comm_count_w2)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input int ph, input int cond, input int trans,
                                input int flt, input int code, input int cnt);
        exp_t e;
        e.ph    = 2'(ph);
        e.cond  = 1'(cond);
        e.trans = 1'(trans);
        e.flt   = 1'(flt);
        e.code  = 3'(code);
        e.cnt   = 16'(cnt);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic service();
        sb_t s;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            s = sb.pop_front();
            $display("txn cyc=%0d gate=%b ph=%0d cond=%0d trans=%0d fault=%0d code=%0d cnt=%0d cnt_w2=%0d",
                     cyc, gate_in, active_phase, conducting, in_transition, fault,
                     fault_code, comm_count, comm_count_w2);
            check("active_phase",  32'(active_phase),  32'(s.e.ph));
            check("conducting",    32'(conducting),    32'(s.e.cond));
            check("in_transition", 32'(in_transition), 32'(s.e.trans));
            check("fault",         32'(fault),         32'(s.e.flt));
            check("fault_code",    32'(fault_code),    32'(s.e.code));
            check("comm_count",    32'(comm_count),    32'(s.e.cnt));
            check("comm_count_w2", 32'(comm_count_w2), 32'(s.e.cnt[1:0]));
        end
    endtask

    // One clock: apply inputs, take the edge, sample 1 time unit later
    task automatic drive(input logic r, input logic [5:0] g);
        rst     = r;
        gate_in = g;
        @(posedge clk);
        cyc++;
        #1;
        service();
    endtask

    task automatic expect_next(input exp_t e);
        sb.push_back('{due: cyc + 1, e: e});
    endtask

    task automatic add(input logic r, input logic [5:0] g, input int len,
                       input logic chk, input exp_t e);
        tbl.push_back('{rst: r, gate: g, len: len, chk: chk, e: e});
    endtask

    initial begin
        exp_t z, a_on, a_tr, b_on, b_tr;
        z = ex(0, 0, 0, 0, 0, 0);

        // Reset release: outputs stay 0 through reset, pair shows two edges later
        expect_next(z);                  drive(1'b1, 6'b110000);
        expect_next(z);                  drive(1'b1, 6'b110000);
        expect_next(z);                  drive(1'b0, 6'b110000);
        expect_next(ex(1, 1, 0, 0, 0, 0)); drive(1'b0, 6'b110000);
        drive(1'b0, 6'b110000);
        drive(1'b0, 6'b110000);
        // Open circuit: third consecutive all-off cycle trips code 4
        repeat (4) drive(1'b0, 6'b100000);
        expect_next(ex(1, 0, 1, 0, 0, 0)); drive(1'b0, 6'b000000);
        expect_next(ex(1, 0, 0, 0, 0, 0)); drive(1'b0, 6'b000000);
        expect_next(ex(1, 0, 0, 0, 0, 0)); drive(1'b0, 6'b000000);
        expect_next(ex(1, 0, 0, 1, 4, 0)); drive(1'b0, 6'b100000);
        expect_next(ex(1, 0, 0, 1, 4, 0)); drive(1'b0, 6'b100000);

        // Commutation table: A<->B five times (fwd and rev), plus a return to same pair
        add(1'b1, 6'b110000, 2, 1'b1, z);
        a_on = ex(1, 1, 0, 0, 0, 0); a_tr = ex(1, 0, 1, 0, 0, 0);
        b_on = ex(2, 1, 0, 0, 0, 1); b_tr = ex(2, 0, 1, 0, 0, 1);
        add(1'b0, 6'b110000, 4, 1'b1, a_on);
        add(1'b0, 6'b100000, 4, 1'b1, a_tr);
        add(1'b0, 6'b101000, 4, 1'b1, a_tr);
        add(1'b0, 6'b001000, 4, 1'b1, a_tr);
        add(1'b0, 6'b001100, 4, 1'b1, b_on);
        add(1'b0, 6'b000100, 4, 1'b1, b_tr);
        add(1'b0, 6'b010100, 4, 1'b1, b_tr);
        add(1'b0, 6'b010000, 4, 1'b1, b_tr);
        add(1'b0, 6'b110000, 4, 1'b1, ex(1, 1, 0, 0, 0, 2));
        add(1'b0, 6'b010000, 4, 1'b1, ex(1, 0, 1, 0, 0, 2));
        add(1'b0, 6'b110000, 4, 1'b1, ex(1, 1, 0, 0, 0, 2));
        add(1'b0, 6'b100000, 4, 1'b1, ex(1, 0, 1, 0, 0, 2));
        add(1'b0, 6'b101000, 4, 1'b1, ex(1, 0, 1, 0, 0, 2));
        add(1'b0, 6'b001000, 4, 1'b1, ex(1, 0, 1, 0, 0, 2));
        add(1'b0, 6'b001100, 4, 1'b1, ex(2, 1, 0, 0, 0, 3));
        add(1'b0, 6'b001000, 4, 1'b1, ex(2, 0, 1, 0, 0, 3));
        add(1'b0, 6'b101000, 4, 1'b1, ex(2, 0, 1, 0, 0, 3));
        add(1'b0, 6'b100000, 4, 1'b1, ex(2, 0, 1, 0, 0, 3));
        add(1'b0, 6'b110000, 4, 1'b1, ex(1, 1, 0, 0, 0, 4));
        add(1'b0, 6'b010000, 4, 1'b1, ex(1, 0, 1, 0, 0, 4));
        add(1'b0, 6'b010100, 4, 1'b1, ex(1, 0, 1, 0, 0, 4));
        add(1'b0, 6'b000100, 4, 1'b1, ex(1, 0, 1, 0, 0, 4));
        add(1'b0, 6'b001100, 4, 1'b1, ex(2, 1, 0, 0, 0, 5));
        // Jump from B pair to A pair: phase and count freeze in FAULT
        add(1'b0, 6'b110000, 4, 1'b1, ex(2, 0, 0, 1, 2, 5));
        add(1'b0, 6'b001100, 4, 1'b1, ex(2, 0, 0, 1, 2, 5));
        // Recovery, then all-off held long in IDLE
        add(1'b1, 6'b000000, 2, 1'b1, z);
        add(1'b0, 6'b000000, 50, 1'b1, z);
        // Dwell violation, latched for 20 cycles
        add(1'b0, 6'b110000, 8, 1'b1, a_on);
        add(1'b0, 6'b100000, 2, 1'b1, a_tr);
        add(1'b0, 6'b101000, 20, 1'b1, ex(1, 0, 0, 1, 3, 0));
        // Illegal beats jump and dwell
        add(1'b1, 6'b000000, 1, 1'b1, z);
        add(1'b0, 6'b100000, 1, 1'b0, z);
        add(1'b0, 6'b111000, 4, 1'b1, ex(0, 0, 0, 1, 1, 0));
        // Mixed-polarity overlap
        add(1'b1, 6'b000000, 1, 1'b1, z);
        add(1'b0, 6'b100100, 4, 1'b1, ex(0, 0, 0, 1, 1, 0));
        // Direct pair-to-pair jump
        add(1'b1, 6'b000000, 1, 1'b1, z);
        add(1'b0, 6'b110000, 4, 1'b1, a_on);
        add(1'b0, 6'b001100, 4, 1'b1, ex(1, 0, 0, 1, 2, 0));
        add(1'b1, 6'b000000, 2, 1'b1, z);

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                for (int k = 0; k < tbl[i].len; k++) begin
                    expect_next(tbl[i].e);
                    drive(1'b1, tbl[i].gate);
                end
            end else begin
                if (tbl[i].chk) begin
                    sb.push_back('{due: cyc + tbl[i].len, e: tbl[i].e});
                end
                for (int k = 0; k < tbl[i].len; k++) begin
                    drive(1'b0, tbl[i].gate);
                end
            end
        end

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/commutation_monitor.md
Name: commutation_monitor

Overview:
Passive checker on the 6-bit gate-drive bus that the matrix-converter commutation FSM produces. It decodes each gate pattern back into a connected load phase and checks every pattern change against the four-step safe-commutation rules. It latches the first violation as a coded fault and counts completed commutations. It sits beside the commutation FSM, feeds the protection/trip logic, and drives no gates.

Parameters:
MIN_DWELL, 4, minimum cycles a gate pattern must hold before it may change (range 1..2^DWELL_W-1)
OPEN_MAX, 2, consecutive all-off cycles allowed once conduction has started
DWELL_W, 8, width of the dwell and open counters
COUNT_W, 16, width of comm_count

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
gate_in  in  6  gate bus: [5]=A fwd, [4]=A rev, [3]=B fwd, [2]=B rev, [1]=C fwd, [0]=C rev
active_phase  out  2  last fully-connected phase: 01=A, 10=B, 11=C, 00=none since reset
conducting  out  1  current pattern is a full bidirectional pair
in_transition  out  1  current pattern is a legal intermediate (non-zero, not a full pair)
fault  out  1  sticky fault flag
fault_code  out  3  1=illegal pattern, 2=multi-bit jump, 3=dwell violation, 4=open-circuit timeout, 0=none
comm_count  out  COUNT_W  completed commutations, wraps modulo 2^COUNT_W

Behaviour:
- Reset (rst high at an edge): g_cur and g_prev = 0. dwell_cnt = all ones. open_cnt = 0. State = IDLE. All outputs = 0.
- Pipeline: g_cur <= gate_in; g_prev <= g_cur. Checks compare g_cur against g_prev. Outputs are registered. A pattern that is stable before edge k is reflected on the outputs after edge k+1 (2-cycle latency).
- Legal patterns:
  - 000000.
  - Any single bit.
  - Full pair of one phase: 110000, 001100, 000011.
  - Same-polarity overlap of two phases: 101000, 100010, 001010 (fwd) and 010100, 010001, 000101 (rev).
  - Everything else is illegal: mixed-polarity overlaps such as 100100, and any pattern with 3 or more bits set.
- Change rules, applied when g_cur != g_prev:
  - Hamming distance must be exactly 1.
  - dwell_cnt of the old pattern must be >= MIN_DWELL.
- dwell_cnt: loads 1 on a change. Increments while the pattern is unchanged. Saturates at all ones.
- open_cnt: increments while g_cur == 0 and state != IDLE. Clears on any non-zero pattern. Fault 4 when open_cnt reaches OPEN_MAX.
- States:
  - IDLE: after reset, no full pair seen yet. All-off is allowed indefinitely. A full pair moves to CONDUCT. A single bit or overlap moves to COMMUTATE.
  - CONDUCT: the pattern is a full pair. active_phase is updated. Any legal change moves to COMMUTATE.
  - COMMUTATE: the pattern is an intermediate or all-off. A full pair moves to CONDUCT. comm_count increments when that pair's phase differs from the previous active_phase and the previous active_phase != 00.
  - FAULT: entered on any violation. fault=1 and fault_code hold until rst. active_phase holds. conducting=0, in_transition=0. comm_count frozen. Input is still sampled but ignored.
- Simultaneous violations in one cycle: the lowest code wins (1 > 2 > 3 > 4). Only the first fault is recorded.
- A change back to the same pair (e.g. A pair, then a single A bit, then the A pair again) is legal and does not count.
- rst mid-operation or in FAULT returns to the full reset state on that edge.

Decomposition:
- Shared package (commutation_pkg), also used by the commutation FSM:
  - Gate-bit index constants.
  - Phase codes (NUL/A/B/C).
  - Full-pair and overlap pattern constants.
  - Fault-code enum.
  - Monitor state enum.
- One sub-module, gate_pattern_classify: combinational. 6-bit pattern in; is_zero, is_single, is_pair, is_overlap, is_illegal, and the pair's phase out.
- Counters and the FSM stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with gate_in=110000 -> all outputs 0 throughout. Release -> active_phase=01 and conducting=1 two edges later.
- Clean A->B, positive current: 110000, 100000, 101000, 001000, 001100, each held 4 cycles -> fault=0; in_transition=1 during the middle patterns; active_phase 01 then 10; comm_count=1.
- Dwell violation: 110000 (8 cycles), then 100000 for 2 cycles, then 101000 -> fault=1, fault_code=3, latched for 20 cycles afterwards.
- Illegal and priority: from 100000 held 1 cycle, drive 111000 -> fault_code=1, not 3. Separate run: hold 100100 -> fault_code=1.
- Jump and open circuit:
  - 110000 then directly 001100 -> fault_code=2.
  - Separate run: 110000, 100000, 000000 for 3 cycles -> fault_code=4 when open_cnt reaches 2.
  - Separate run: 000000 held 50 cycles after reset -> no fault.
- Wrap and recovery:
  - With COUNT_W=2, perform 5 legal A<->B commutations -> comm_count=1.
  - Force a fault, then pulse rst -> fault=0, fault_code=0, comm_count=0.
